// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite-DMA engine: trigger/destination addresses
// and the transfer state encoding used by the bus mux and PPU register decode.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          XFER_LEN      = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 pauses the CPU and copies page {page,00..FF}
// to the OAM data port, alternating bus reads and writes on get/put cycles.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mw,
  input  logic [7:0]  bus_din,
  output logic        cpu_pause,
  output logic [15:0] dma_aout,
  output logic [7:0]  dma_dout,
  output logic        dma_mr,
  output logic        dma_mw
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
    end else if (ce) begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_mw && (cpu_aout == DMA_REG_ADDR)) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      // Reads must land on parity 0; an odd halt cycle already sets that up.
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so no cpu_* input reaches them.
  always_comb begin
    cpu_pause = (state_q != IDLE);
    dma_aout  = 16'h0000;
    dma_dout  = 8'h00;
    dma_mr    = 1'b0;
    dma_mw    = 1'b0;
    case (state_q)
      READ: begin
        dma_aout = {page_q, idx_q};
        dma_mr   = 1'b1;
      end
      WRITE: begin
        dma_aout = OAM_DATA_ADDR;
        dma_dout = data_q;
        dma_mw   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
